// File: rtl/timer_sequencer.sv
// Feeds durations to the 16-bit countdown timer. Requests are queued in a
// small FIFO and issued one at a time as single-cycle load strobes after the
// timer goes idle. Zero-length requests are accepted and then dropped, so the
// timer never sees a zero load. Each completed interval produces a done pulse.
//
//   state | meaning
//   IDLE  | nothing in flight; wait for a queued entry
//   LOAD  | present FIFO head on cycles, strobe load, pop the head
//   RUN   | timer counting; wait for busy low, then pulse done
module timer_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_cycles,
  output logic             req_ready,
  input  logic             flush,
  input  logic             timer_busy,
  output logic             load,
  output logic [WIDTH-1:0] cycles,
  output logic             done,
  output logic             zero_drop,
  output logic [AW:0]      pending
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_after_push;
  logic [WIDTH-1:0] head;
  logic             full;
  logic             accept;
  logic             push;
  logic             pop;

  // Ready ignores any same-cycle pop, keeping timer_busy off the ready path.
  assign full      = (count == FULL_COUNT);
  assign req_ready = !full && !flush;
  assign accept    = req_valid && req_ready;
  assign push      = accept && (req_cycles != '0);
  assign pop       = (state == LOAD) && (count != '0);
  assign pending   = count;

  // A push in the same cycle as RUN->LOAD into an empty FIFO is the new head.
  assign head             = (count == '0) ? req_cycles : mem[rd_ptr];
  assign count_after_push = flush ? '0 : (count + (AW+1)'(push));

  // FIFO storage; entries are meaningless once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= req_cycles;
  end

  // FIFO pointers and occupancy; flush overrides push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // State register, captured duration and the zero-drop flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cycles    <= '0;
      zero_drop <= 1'b0;
    end else begin
      state     <= state_next;
      zero_drop <= accept && (req_cycles == '0);
      if (state_next == LOAD && state != LOAD) cycles <= head;
    end
  end

  // Next-state and strobe decode; a flush in IDLE discards the entry rather
  // than loading it.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 && !flush) state_next = LOAD;
      end
      LOAD: begin
        load       = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (!timer_busy) begin
          done       = 1'b1;
          state_next = (count_after_push != '0) ? LOAD : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer with a behavioural countdown timer model.
module tb_timer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [15:0] req_cycles;
  logic        req_ready;
  logic        flush;
  logic        timer_busy;
  logic        load;
  logic [15:0] cycles;
  logic        done;
  logic        zero_drop;
  logic [2:0]  pending;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [15:0] rem;

  int load_t[$];
  int load_v[$];
  int done_t[$];
  int zd_t[$];

  timer_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_cycles(req_cycles),
    .req_ready(req_ready), .flush(flush), .timer_busy(timer_busy), .load(load),
    .cycles(cycles), .done(done), .zero_drop(zero_drop), .pending(pending)
  );

  always #5 clk = ~clk;

  // Countdown timer: busy rises the cycle after load and lasts N cycles.
  always @(posedge clk or posedge reset) begin
    if (reset)         rem <= '0;
    else if (load)     rem <= cycles;
    else if (rem != 0) rem <= rem - 16'd1;
  end
  assign timer_busy = (rem != 0);

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (load) begin
        load_t.push_back(cyc);
        load_v.push_back(int'(cycles));
      end
      if (done)      done_t.push_back(cyc);
      if (zero_drop) zd_t.push_back(cyc);
    end
  end

  task automatic clear_logs();
    load_t.delete(); load_v.delete(); done_t.delete(); zd_t.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold a request until accepted; returns the handshake cycle.
  task automatic push(input logic [15:0] v, output int hs);
    hs = -1;
    req_valid = 1'b1;
    req_cycles = v;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready) begin
        hs = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    tests++;
    if (hs < 0) begin
      fails++;
      $display("FAIL push_timeout: value %0d never accepted", v);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_cycles = '0; flush = 1'b0;
    wait_cycles(2);
    tests++; if (load !== 1'b0)   begin fails++; $display("FAIL reset_load: got %b expected 0", load); end
    tests++; if (cycles !== 16'd0) begin fails++; $display("FAIL reset_cycles: got %0d expected 0", cycles); end
    tests++; if (done !== 1'b0)   begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (zero_drop !== 1'b0) begin fails++; $display("FAIL reset_zero_drop: got %b expected 0", zero_drop); end
    reset = 1'b0;
    @(negedge clk);
    tests++; if (pending !== 3'd0) begin fails++; $display("FAIL reset_pending: got %0d expected 0", pending); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int hs;
    clear_logs();
    push(16'd3, hs);
    wait_cycles(10);
    tests++; if (load_v.size() != 1) begin fails++; $display("FAIL single_nloads: got %0d expected 1", load_v.size()); end
    tests++; if (done_t.size() != 1) begin fails++; $display("FAIL single_ndone: got %0d expected 1", done_t.size()); end
    if (load_v.size() >= 1) begin
      tests++; if (load_v[0] != 3) begin fails++; $display("FAIL single_cycles: got %0d expected 3", load_v[0]); end
      tests++; if (load_t[0] != hs + 2) begin fails++; $display("FAIL single_load_lat: got %0d expected %0d", load_t[0], hs + 2); end
      if (done_t.size() >= 1) begin
        tests++; if (done_t[0] != load_t[0] + 4) begin fails++; $display("FAIL single_done_lat: got %0d expected %0d", done_t[0], load_t[0] + 4); end
      end
    end
    tests++; if (pending !== 3'd0) begin fails++; $display("FAIL single_pending: got %0d expected 0", pending); end
  endtask

  task automatic test_back_to_back();
    int hs;
    int exp_v[3] = '{5, 2, 7};
    clear_logs();
    push(16'd5, hs);
    push(16'd2, hs);
    push(16'd7, hs);
    wait_cycles(30);
    tests++; if (load_v.size() != 3) begin fails++; $display("FAIL b2b_nloads: got %0d expected 3", load_v.size()); end
    tests++; if (done_t.size() != 3) begin fails++; $display("FAIL b2b_ndone: got %0d expected 3", done_t.size()); end
    if (load_v.size() == 3 && done_t.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        tests++; if (load_v[i] != exp_v[i]) begin fails++; $display("FAIL b2b_value%0d: got %0d expected %0d", i, load_v[i], exp_v[i]); end
        tests++; if (done_t[i] != load_t[i] + exp_v[i] + 1) begin fails++; $display("FAIL b2b_done%0d: got %0d expected %0d", i, done_t[i], load_t[i] + exp_v[i] + 1); end
      end
      for (int i = 0; i < 2; i++) begin
        tests++; if (load_t[i+1] != done_t[i] + 1) begin fails++; $display("FAIL b2b_gap%0d: got %0d expected %0d", i, load_t[i+1], done_t[i] + 1); end
      end
    end
  endtask

  task automatic test_full();
    int hs;
    int exp_v[6] = '{20, 1, 2, 3, 4, 5};
    clear_logs();
    push(16'd20, hs);
    wait_cycles(4);
    for (int i = 1; i <= 4; i++) push(16'(i), hs);
    @(negedge clk);
    tests++; if (pending !== 3'd4) begin fails++; $display("FAIL full_pending: got %0d expected 4", pending); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b expected 0", req_ready); end
    @(posedge clk); #1;
    push(16'd5, hs);
    if (load_t.size() >= 2) begin
      tests++; if (hs != load_t[1] + 1) begin fails++; $display("FAIL full_reaccept: got %0d expected %0d", hs, load_t[1] + 1); end
    end
    wait_cycles(60);
    tests++; if (load_v.size() != 6) begin fails++; $display("FAIL full_nloads: got %0d expected 6", load_v.size()); end
    if (load_v.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        tests++; if (load_v[i] != exp_v[i]) begin fails++; $display("FAIL full_value%0d: got %0d expected %0d", i, load_v[i], exp_v[i]); end
      end
    end
  endtask

  task automatic test_zero();
    int hs;
    int hs0;
    clear_logs();
    push(16'd10, hs);
    wait_cycles(4);
    push(16'd4, hs);
    @(negedge clk);
    tests++; if (pending !== 3'd1) begin fails++; $display("FAIL zero_pending_before: got %0d expected 1", pending); end
    @(posedge clk); #1;
    push(16'd0, hs0);
    @(negedge clk);
    tests++; if (pending !== 3'd1) begin fails++; $display("FAIL zero_pending_after: got %0d expected 1", pending); end
    @(posedge clk); #1;
    push(16'd6, hs);
    wait_cycles(40);
    tests++; if (zd_t.size() != 1) begin fails++; $display("FAIL zero_pulses: got %0d expected 1", zd_t.size()); end
    if (zd_t.size() == 1) begin
      tests++; if (zd_t[0] != hs0 + 1) begin fails++; $display("FAIL zero_timing: got %0d expected %0d", zd_t[0], hs0 + 1); end
    end
    tests++; if (load_v.size() != 3) begin fails++; $display("FAIL zero_nloads: got %0d expected 3", load_v.size()); end
    if (load_v.size() == 3) begin
      tests++; if (load_v[1] != 4) begin fails++; $display("FAIL zero_value1: got %0d expected 4", load_v[1]); end
      tests++; if (load_v[2] != 6) begin fails++; $display("FAIL zero_value2: got %0d expected 6", load_v[2]); end
    end
    foreach (load_v[i]) begin
      tests++; if (load_v[i] == 0) begin fails++; $display("FAIL zero_loaded: load %0d got 0 expected nonzero", i); end
    end
  endtask

  task automatic test_flush();
    int hs;
    clear_logs();
    push(16'd15, hs);
    wait_cycles(4);
    push(16'd1, hs);
    push(16'd2, hs);
    push(16'd3, hs);
    flush = 1'b1;
    @(negedge clk);
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b expected 0", req_ready); end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    tests++; if (pending !== 3'd0) begin fails++; $display("FAIL flush_pending: got %0d expected 0", pending); end
    @(posedge clk); #1;
    wait_cycles(25);
    tests++; if (load_v.size() != 1) begin fails++; $display("FAIL flush_nloads: got %0d expected 1", load_v.size()); end
    tests++; if (done_t.size() != 1) begin fails++; $display("FAIL flush_ndone: got %0d expected 1", done_t.size()); end
  endtask

  task automatic test_reset_mid_run();
    int hs;
    clear_logs();
    push(16'd30, hs);
    wait_cycles(5);
    push(16'd1, hs);
    push(16'd2, hs);
    @(negedge clk);
    tests++; if (pending !== 3'd2) begin fails++; $display("FAIL rst_pending_before: got %0d expected 2", pending); end
    #2 reset = 1'b1;
    #1;
    tests++; if (cycles !== 16'd0) begin fails++; $display("FAIL rst_async_cycles: got %0d expected 0", cycles); end
    tests++; if (pending !== 3'd0) begin fails++; $display("FAIL rst_async_pending: got %0d expected 0", pending); end
    tests++; if (load !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rst_async_strobes: got load %b done %b expected 0 0", load, done); end
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(5);
    tests++; if (done_t.size() != 0) begin fails++; $display("FAIL rst_no_done: got %0d expected 0", done_t.size()); end
    tests++; if (load_t.size() != 1) begin fails++; $display("FAIL rst_no_reload: got %0d expected 1", load_t.size()); end
    test_single();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_zero();
    test_flush();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
